// File: rtl/umni_pkg.sv
// umni_pkg: shared state encoding and defaults for the PC sequencer
package umni_pkg;
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    BUSCA   = 2'd1,
    EXECUTA = 2'd2,
    PARADO  = 2'd3
  } estado_t;
  localparam int LARGURA_END = 7;
  localparam int MAX_ESPERA_PADRAO = 15;
endpackage

// File: rtl/sequenciador_pc_7bits_contador_espera.sv
// contador_espera: fetch wait counter; chegou flags that the current miss is the last one allowed
module contador_espera
  import umni_pkg::*;
#(
  parameter int MAX_ESPERA = MAX_ESPERA_PADRAO
) (
  input  logic clk,
  input  logic reset,
  input  logic limpa,
  input  logic incrementa,
  output logic chegou
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else r_cnt <= limpa ? '0 : incrementa ? r_cnt + 8'd1 : r_cnt;
  assign chegou = r_cnt == 8'(MAX_ESPERA - 1);
endmodule

// File: rtl/sequenciador_pc_7bits.sv
// sequenciador_pc_7bits: fetch/execute PC sequencer with fetch timeout, jumps and halt.
// Define UMNI_PC_RETORNO_EN to enable the one-level call/return register.
module sequenciador_pc_7bits
  import umni_pkg::*;
#(
  parameter int LARGURA = LARGURA_END,
  parameter int END_INICIAL = 0,
  parameter int MAX_ESPERA = MAX_ESPERA_PADRAO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inicia,
  input  logic               mem_pronto,
  input  logic               salto,
  input  logic               incondicional,
  input  logic               condicao,
  input  logic [LARGURA-1:0] endereco_salto,
  input  logic               halt,
  input  logic               chamada,
  input  logic               retorno,
  output logic [LARGURA-1:0] proximo,
  output logic               le_mem,
  output logic               ocupado,
  output logic               parado,
  output logic               erro,
  output logic               estouro
);
  estado_t r_estado, w_estado;
  logic [LARGURA-1:0] r_pc, w_pc, w_pc_inc, r_ret, w_ret;
  logic r_erro, w_erro, r_estouro, w_estouro;
  logic w_limpa, w_incr, w_chegou, w_salto_ef;
  contador_espera #(.MAX_ESPERA(MAX_ESPERA)) u_espera (
    .clk(clk), .reset(reset), .limpa(w_limpa), .incrementa(w_incr), .chegou(w_chegou)
  );
  assign w_pc_inc = r_pc + 1'b1;
  assign w_salto_ef = salto & (incondicional | condicao);
`ifdef UMNI_PC_RETORNO_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) r_ret <= '0;
    else r_ret <= w_ret;
`else
  logic w_unused;
  assign w_unused = chamada ^ retorno;
  assign r_ret = '0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_estado <= OCIOSO;
      r_pc <= LARGURA'(END_INICIAL);
      r_erro <= 1'b0;
      r_estouro <= 1'b0;
    end else begin
      r_estado <= w_estado;
      r_pc <= w_pc;
      r_erro <= w_erro;
      r_estouro <= w_estouro;
    end
  always_comb begin
    w_estado = r_estado;
    w_pc = r_pc;
    w_ret = r_ret;
    w_erro = r_erro;
    w_estouro = 1'b0;
    w_limpa = 1'b1;
    w_incr = 1'b0;
    case (r_estado)
      OCIOSO: w_estado = inicia ? BUSCA : OCIOSO;
      BUSCA: begin
        w_limpa = mem_pronto | w_chegou;
        w_incr = ~w_limpa;
        w_estado = mem_pronto ? EXECUTA : w_chegou ? PARADO : BUSCA;
        w_erro = r_erro | (~mem_pronto & w_chegou);
      end
      EXECUTA: begin
        w_estado = halt ? PARADO : BUSCA;
        if (halt) w_pc = r_pc;
        else if (w_salto_ef) begin
          w_pc = endereco_salto;
`ifdef UMNI_PC_RETORNO_EN
          w_ret = chamada ? w_pc_inc : r_ret;
`endif
        end
`ifdef UMNI_PC_RETORNO_EN
        else if (retorno) w_pc = r_ret;
`endif
        else begin
          w_pc = w_pc_inc;
          w_estouro = &r_pc;
        end
      end
      PARADO: if (inicia) begin
        w_estado = BUSCA;
        w_pc = LARGURA'(END_INICIAL);
        w_erro = 1'b0;
      end
      default: w_estado = OCIOSO;
    endcase
  end
  assign proximo = r_pc;
  assign le_mem = r_estado == BUSCA;
  assign ocupado = r_estado == BUSCA || r_estado == EXECUTA;
  assign parado = r_estado == PARADO;
  assign erro = r_erro;
  assign estouro = r_estouro;
endmodule

// File: tb/tb_sequenciador_pc_7bits.sv
// tb_sequenciador_pc_7bits: directed plan plus random traffic against a behavioural PC model
module tb_sequenciador_pc_7bits;
`ifdef UMNI_PC_RETORNO_EN
  localparam bit RET = 1'b1;
`else
  localparam bit RET = 1'b0;
`endif
  localparam int MAXE = 15;
  logic clk = 1'b0, reset = 1'b1;
  logic inicia, mem_pronto, salto, incondicional, condicao, halt, chamada, retorno;
  logic [6:0] endereco_salto;
  logic [6:0] proximo;
  logic le_mem, ocupado, parado, erro, estouro;
  int vectors = 0, miscompares = 0;
  bit armed = 1'b0;
  // model: phase 0 idle, 1 fetch, 2 execute, 3 halted
  int m_st, m_pc, m_wait, m_ret;
  bit m_erro, m_est;

  sequenciador_pc_7bits dut (
    .clk(clk), .reset(reset), .inicia(inicia), .mem_pronto(mem_pronto), .salto(salto),
    .incondicional(incondicional), .condicao(condicao), .endereco_salto(endereco_salto),
    .halt(halt), .chamada(chamada), .retorno(retorno), .proximo(proximo), .le_mem(le_mem),
    .ocupado(ocupado), .parado(parado), .erro(erro), .estouro(estouro)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_st = 0; m_pc = 0; m_wait = 0; m_ret = 0; m_erro = 0; m_est = 0;
  endfunction

  function automatic void model_edge();
    m_est = 0;
    if (m_st == 0) begin
      if (inicia) m_st = 1;
    end else if (m_st == 1) begin
      if (mem_pronto) begin
        m_st = 2; m_wait = 0;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait == MAXE) begin m_st = 3; m_erro = 1; m_wait = 0; end
      end
    end else if (m_st == 2) begin
      if (halt) m_st = 3;
      else begin
        m_st = 1;
        if (salto && (incondicional || condicao)) begin
          if (RET && chamada) m_ret = (m_pc + 1) % 128;
          m_pc = int'(endereco_salto);
        end else if (RET && retorno) m_pc = m_ret;
        else begin
          m_est = (m_pc == 127);
          m_pc = (m_pc + 1) % 128;
        end
      end
    end else if (inicia) begin
      m_st = 1; m_pc = 0; m_erro = 0;
    end
  endfunction

  always @(negedge clk) if (armed && !reset) begin
    vectors++;
    if (int'(proximo) != m_pc || le_mem != (m_st == 1) || ocupado != (m_st == 1 || m_st == 2) ||
        parado != (m_st == 3) || erro != m_erro || estouro != m_est) begin
      miscompares++;
      $display("FAIL model t=%0t: got pc=%0d le=%b oc=%b pa=%b er=%b es=%b, expected pc=%0d le=%b oc=%b pa=%b er=%b es=%b",
        $time, proximo, le_mem, ocupado, parado, erro, estouro,
        m_pc, m_st == 1, m_st == 1 || m_st == 2, m_st == 3, m_erro, m_est);
    end
  end

  task automatic chk(input string n, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic clr();
    inicia = 0; mem_pronto = 0; salto = 0; incondicional = 0; condicao = 0;
    halt = 0; chamada = 0; retorno = 0; endereco_salto = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic jump_to(input int t);
    clr(); salto = 1; incondicional = 1; endereco_salto = 7'(t);
    tick();
    clr(); mem_pronto = 1;
  endtask

  initial begin
    clr();
    model_reset();
    #12;
    chk("reset_proximo", proximo, 0);
    chk("reset_ocupado", ocupado, 0);
    chk("reset_flags", {le_mem, parado, erro, estouro}, 0);
    @(negedge clk);
    reset = 0;
    armed = 1;
    inicia = 1; mem_pronto = 1;
    tick();
    inicia = 0;
    chk("first_busca_le", le_mem, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("exec_le_low", le_mem, 0);
      tick();
      chk("loop_proximo", proximo, k);
      chk("loop_le_high", le_mem, 1);
    end
    tick();
    jump_to(127);
    chk("jump_127", proximo, 127);
    tick();
    tick();
    chk("wrap_proximo", proximo, 0);
    chk("wrap_estouro", estouro, 1);
    tick();
    chk("estouro_one_cycle", estouro, 0);
    clr(); salto = 1; endereco_salto = 7'd40;
    tick();
    chk("cond_false_incr", proximo, 1);
    clr(); mem_pronto = 1;
    tick();
    clr(); salto = 1; condicao = 1; endereco_salto = 7'd40;
    tick();
    chk("cond_true_jump", proximo, 40);
    clr(); mem_pronto = 1;
    tick();
    clr(); salto = 1; incondicional = 1; halt = 1; endereco_salto = 7'd99;
    tick();
    chk("halt_parado", parado, 1);
    chk("halt_pc_held", proximo, 40);
    clr(); inicia = 1;
    tick();
    clr();
    for (int k = 0; k < MAXE - 1; k++) tick();
    chk("timeout_not_yet", parado, 0);
    tick();
    chk("timeout_parado", parado, 1);
    chk("timeout_erro", erro, 1);
    inicia = 1;
    tick();
    inicia = 0;
    chk("restart_erro", erro, 0);
    chk("restart_pc", proximo, 0);
    chk("restart_busca", le_mem, 1);
    mem_pronto = 1;
    tick();
    jump_to(9);
    tick();
    chk("pre_reset_pc", proximo, 9);
    #2 reset = 1;
    model_reset();
    #1;
    chk("async_reset_pc", proximo, 0);
    chk("async_reset_ocupado", ocupado, 0);
    @(negedge clk);
    reset = 0;
    clr(); inicia = 1; mem_pronto = 1;
    tick();
    clr(); mem_pronto = 1;
    tick();
    jump_to(5);
    tick();
    clr(); salto = 1; incondicional = 1; chamada = 1; endereco_salto = 7'd60;
    tick();
    chk("call_target", proximo, 60);
    clr(); mem_pronto = 1;
    tick();
    clr(); retorno = 1;
    tick();
    chk("return_pc", proximo, RET ? 6 : 61);
    for (int seg = 0; seg < 40; seg++) begin
      int pr = (seg % 5 == 4) ? 2 : 80;
      for (int c = 0; c < 60; c++) begin
        inicia = ($urandom_range(0, 99) < 20);
        mem_pronto = ($urandom_range(0, 99) < pr);
        salto = $urandom_range(0, 1);
        incondicional = ($urandom_range(0, 3) == 0);
        condicao = $urandom_range(0, 1);
        halt = ($urandom_range(0, 15) == 0);
        chamada = $urandom_range(0, 1);
        retorno = ($urandom_range(0, 2) == 0);
        endereco_salto = (($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom));
        tick();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sequenciador_pc_7bits.md
Name: sequenciador_pc_7bits

Overview:
- Program-counter sequencer that produces the next 7-bit instruction address.
- Its `proximo` output drives the `entrada` of the 7-bit address register (registrador7Bits) one stage downstream.
- Runs a fetch/execute FSM with a memory read handshake and a fetch timeout.
- Supports conditional/unconditional jumps and halt.

Parameters:
- LARGURA, 7, address width; `proximo` and `endereco_salto` width.
- END_INICIAL, 0, PC value after reset and on restart.
- MAX_ESPERA, 15, max BUSCA cycles without `mem_pronto` before an error halt (legal range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inicia  in  1  start/restart request; sampled only in OCIOSO or PARADO.
- mem_pronto  in  1  memory read complete; sampled only in BUSCA.
- salto  in  1  jump request; sampled in EXECUTA.
- incondicional  in  1  jump ignores `condicao` when 1.
- condicao  in  1  jump condition flag.
- endereco_salto  in  LARGURA  jump target.
- halt  in  1  halt request; sampled in EXECUTA.
- chamada  in  1  call (effective only with the optional feature).
- retorno  in  1  return (effective only with the optional feature).
- proximo  out  LARGURA  registered PC; feeds the address register.
- le_mem  out  1  memory read request; high throughout BUSCA.
- ocupado  out  1  high in BUSCA or EXECUTA.
- parado  out  1  high in PARADO.
- erro  out  1  sticky fetch-timeout flag.
- estouro  out  1  one-cycle pulse when increment wraps from 127 to 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high; clock port `clk`, reset port `reset`.
- Reset values (immediate, independent of clk): `proximo`=END_INICIAL, state=OCIOSO, `le_mem`=0, `ocupado`=0, `parado`=0, `erro`=0, `estouro`=0, wait counter=0, return register=0.
- All outputs are registered or pure decodes of the state register; no input-to-output combinational path.
- State OCIOSO: `inicia`=1 -> BUSCA on the next edge.
- State BUSCA:
  - `le_mem`=1; `proximo` is held.
  - Edge with `mem_pronto`=1 -> EXECUTA; wait counter cleared.
  - Otherwise the wait counter increments.
  - When the counter reaches MAX_ESPERA with no `mem_pronto` -> PARADO with `erro`=1.
- State EXECUTA: exactly one cycle, then one action at the closing edge. Priority:
  - `halt` -> PARADO; PC unchanged.
  - else (`salto` & (`incondicional` | `condicao`)) -> PC=`endereco_salto`, go BUSCA.
  - else -> PC=PC+1 modulo 2^LARGURA, go BUSCA.
  - 127+1 -> 0 pulses `estouro` for exactly one cycle. A jump to 0 does not pulse it.
- State PARADO: `parado`=1; `inicia`=1 -> PC=END_INICIAL, `erro` cleared, go BUSCA.
- `inicia` is ignored in BUSCA and EXECUTA.
- Latency: the new PC appears on `proximo` the cycle after EXECUTA. The downstream register shows it one further edge later.
- Minimum loop: 2 cycles per instruction, when `mem_pronto` is high in the first BUSCA cycle.
- Reset asserted mid-BUSCA or mid-EXECUTA aborts immediately to the reset values; no partial PC update survives.
- Unused state encodings return to OCIOSO on the next edge.

Optional Feature:
- Macro: UMNI_PC_RETORNO_EN.
- With the macro:
  - In EXECUTA, an effective jump with `chamada`=1 saves PC+1 (wrapping) into a one-level return register.
  - In EXECUTA, `retorno`=1 (no halt, no effective jump) loads PC from the return register.
  - Priority: `halt` > jump/call > `retorno` > increment.
  - A second call overwrites the saved value.
- Without the macro: `chamada` and `retorno` are ignored. The ports remain, a call acts as a plain jump, and a return acts as an increment.

Decomposition:
- Shared package `umni_pkg`:
  - State encodings: OCIOSO=2'd0, BUSCA=2'd1, EXECUTA=2'd2, PARADO=2'd3.
  - LARGURA_END=7.
  - Default MAX_ESPERA.
- One sub-module `contador_espera`: clear/increment timeout counter with a `chegou` output. This isolates the timeout from the FSM.

Test Plan:
- Reset then `inicia` pulse, `mem_pronto` tied 1 -> `proximo` reads 0,1,2,3 every 2 cycles; `le_mem` high on alternate cycles.
- PC forced to 127 via jump, then increment -> `proximo`=0 and `estouro` high for exactly 1 cycle.
- `salto`=1, `incondicional`=0, `condicao`=0, target 40 -> PC increments. Same with `condicao`=1 -> `proximo`=40. `halt`=1 together with `salto`=1 -> PARADO, PC unchanged.
- `mem_pronto` held 0 in BUSCA -> after 15 cycles `parado`=1 and `erro`=1. Then `inicia` -> `erro`=0, `proximo`=0, BUSCA.
- Reset asserted between edges during EXECUTA with PC=9 -> `proximo`=0 and `ocupado`=0 immediately, before the next edge.
- With UMNI_PC_RETORNO_EN: call at PC=5 to 60, then `retorno` -> `proximo`=6. Without the macro, the same `retorno` -> `proximo`=61.
